// File: rtl/jzjpcc_mmio_pkg.sv
// jzjpcc MMIO port block: shared types and address helpers.
// Region base, group decode and byte-lane helpers live here.
package jzjpcc_mmio_pkg;

    typedef enum logic [1:0] {
        MMIO_IN,
        MMIO_OUT,
        MMIO_DIR,
        MMIO_EDGE
    } mmio_group_t;

    typedef enum logic {
        ARMING,
        ARMED
    } arm_state_t;

    localparam int unsigned WORD_BITS = 32;

    function automatic logic [29:0] regionBase(input int numPorts);
        return 30'(32'h4000_0000 - 32'(4 * numPorts));
    endfunction

    // IN/OUT occupy the upper half of the region, keeping the legacy
    // FFFFFFC0/FFFFFFE0 port addresses for the default eight channels.
    function automatic mmio_group_t groupOf(input logic [1:0] field);
        return mmio_group_t'(field ^ 2'b10);
    endfunction

    function automatic logic [31:0] expandMask(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}},
                {8{mask[1]}}, {8{mask[0]}}};
    endfunction

    function automatic logic [31:0] mergeBytes(
        input logic [31:0] oldWord,
        input logic [31:0] newWord,
        input logic [31:0] laneMask
    );
        return (oldWord & ~laneMask) | (newWord & laneMask);
    endfunction

endpackage

// File: rtl/jzjpcc_mmio_sync.sv
// Per-channel input synchroniser with previous-sample register.
// rise flags bits that went 0->1 between consecutive synchronised samples.
module jzjpcc_mmio_sync
    import jzjpcc_mmio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WORD_BITS-1:0] asyncIn,
    output logic [WORD_BITS-1:0] syncIn,
    output logic [WORD_BITS-1:0] rise
);

    logic [WORD_BITS-1:0] prev;

    if (SYNC_STAGES == 0) begin : gBypass
        assign syncIn = asyncIn;
    end else begin : gChain
        localparam int SW = WORD_BITS * SYNC_STAGES;
        logic [SW-1:0] shreg;

        always_ff @(posedge clock) begin
            if (reset) begin
                shreg <= '0;
            end else begin
                shreg <= SW'({shreg, asyncIn});
            end
        end

        assign syncIn = shreg[SW-1 -: WORD_BITS];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= syncIn;
        end
    end

    assign rise = syncIn & ~prev;

endmodule

// File: rtl/jzjpcc_mmio_ports.sv
// Memory-mapped I/O ports: IN/OUT/DIR/EDGE register groups per channel.
// Read data is registered; edge capture is gated until the syncs settle.
module jzjpcc_mmio_ports
    import jzjpcc_mmio_pkg::*;
#(
    parameter int NUM_PORTS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [29:0]                         memAddress,
    input  logic                                memWriteEnable,
    input  logic [3:0]                          memByteMask,
    input  logic [31:0]                         memDataToWrite,
    output logic                                mmioSelected,
    output logic [31:0]                         memDataRead,
    input  logic [NUM_PORTS-1:0][WORD_BITS-1:0] mmioInputs,
    output logic [NUM_PORTS-1:0][WORD_BITS-1:0] mmioOutputs,
    output logic [NUM_PORTS-1:0][WORD_BITS-1:0] mmioDirection,
    output logic                                edgePending
);

    localparam int          LP        = $clog2(NUM_PORTS);
    localparam logic [29:0] BASE      = regionBase(NUM_PORTS);
    localparam logic [5:0]  PORT_MASK = 6'(NUM_PORTS - 1);
    localparam logic [2:0]  ARM_LOAD  = 3'(SYNC_STAGES + 1);

    logic [29:0]       offset;
    logic [1:0]        groupBits;
    mmio_group_t       group;
    logic [5:0]        portSel;
    logic              wrHit;
    logic [31:0]       wrMask;

    arm_state_t        armState;
    logic [2:0]        armCount;
    logic              armed;

    logic [NUM_PORTS-1:0]              edgeAny;
    logic [NUM_PORTS:0][WORD_BITS-1:0] readChain;

    assign offset       = memAddress - BASE;
    assign groupBits    = 2'(offset >> LP);
    assign group        = groupOf(groupBits);
    assign portSel      = 6'(offset) & PORT_MASK;
    assign mmioSelected = (memAddress >= BASE);
    assign wrHit        = mmioSelected & memWriteEnable;
    assign wrMask       = expandMask(memByteMask);
    assign armed        = (armState == ARMED);

    // Hold off edge capture while reset zeros drain out of the syncs.
    always_ff @(posedge clock) begin
        if (reset) begin
            armState <= ARMING;
            armCount <= ARM_LOAD;
        end else if (armState == ARMING) begin
            if (armCount == 3'd0) begin
                armState <= ARMED;
            end else begin
                armCount <= armCount - 3'd1;
            end
        end
    end

    assign readChain[0] = '0;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
        logic [WORD_BITS-1:0] syncIn;
        logic [WORD_BITS-1:0] rise;
        logic [WORD_BITS-1:0] outQ;
        logic [WORD_BITS-1:0] dirQ;
        logic [WORD_BITS-1:0] edgeQ;
        logic [WORD_BITS-1:0] edgeClr;
        logic [WORD_BITS-1:0] edgeSet;
        logic [WORD_BITS-1:0] rdVal;
        logic                 hit;
        logic                 wrOut;
        logic                 wrDir;

        jzjpcc_mmio_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) uSync (
            .clock  (clock),
            .reset  (reset),
            .asyncIn(mmioInputs[p]),
            .syncIn (syncIn),
            .rise   (rise)
        );

        assign hit   = mmioSelected && (portSel == 6'(p));
        assign wrOut = wrHit && hit && (group == MMIO_OUT);
        assign wrDir = wrHit && hit && (group == MMIO_DIR);

        assign edgeClr = (wrHit && hit && (group == MMIO_EDGE))
                       ? (memDataToWrite & wrMask) : '0;
        assign edgeSet = armed ? rise : '0;

        always_ff @(posedge clock) begin
            if (reset) begin
                outQ  <= '0;
                dirQ  <= '0;
                edgeQ <= '0;
            end else begin
                if (wrOut) begin
                    outQ <= mergeBytes(outQ, memDataToWrite, wrMask);
                end
                if (wrDir) begin
                    dirQ <= mergeBytes(dirQ, memDataToWrite, wrMask);
                end
                // Set is applied after clear so a fresh edge survives W1C.
                edgeQ <= (edgeQ & ~edgeClr) | edgeSet;
            end
        end

        always_comb begin
            rdVal = '0;
            if (hit) begin
                unique case (group)
                    MMIO_IN:   rdVal = syncIn;
                    MMIO_OUT:  rdVal = outQ;
                    MMIO_DIR:  rdVal = dirQ;
                    MMIO_EDGE: rdVal = edgeQ;
                    default:   rdVal = '0;
                endcase
            end
        end

        assign readChain[p+1]   = readChain[p] | rdVal;
        assign mmioOutputs[p]   = outQ;
        assign mmioDirection[p] = dirQ;
        assign edgeAny[p]       = |edgeQ;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            memDataRead <= '0;
        end else begin
            memDataRead <= readChain[NUM_PORTS];
        end
    end

    assign edgePending = |edgeAny;

endmodule

// File: tb/tb_jzjpcc_mmio_ports.sv
// Directed bench for jzjpcc_mmio_ports: vector table plus edge/reset sequences.
// Three instances cover the default, single-port and 64-port configurations.
module tb_jzjpcc_mmio_ports;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] memAddress = '0;
    logic        memWriteEnable = 1'b0;
    logic [3:0]  memByteMask = '0;
    logic [31:0] memDataToWrite = '0;

    logic             sel8, sel1, sel64;
    logic [31:0]      rd8, rd1, rd64;
    logic             ep8, ep1, ep64;
    logic [7:0][31:0] in8, out8, dir8;
    logic [0:0][31:0] in1, out1, dir1;
    logic [63:0][31:0] in64, out64, dir64;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    jzjpcc_mmio_ports #(.NUM_PORTS(8), .SYNC_STAGES(2)) u8 (
        .clock(clock), .reset(reset), .memAddress(memAddress),
        .memWriteEnable(memWriteEnable), .memByteMask(memByteMask),
        .memDataToWrite(memDataToWrite), .mmioSelected(sel8),
        .memDataRead(rd8), .mmioInputs(in8), .mmioOutputs(out8),
        .mmioDirection(dir8), .edgePending(ep8)
    );

    jzjpcc_mmio_ports #(.NUM_PORTS(1), .SYNC_STAGES(0)) u1 (
        .clock(clock), .reset(reset), .memAddress(memAddress),
        .memWriteEnable(memWriteEnable), .memByteMask(memByteMask),
        .memDataToWrite(memDataToWrite), .mmioSelected(sel1),
        .memDataRead(rd1), .mmioInputs(in1), .mmioOutputs(out1),
        .mmioDirection(dir1), .edgePending(ep1)
    );

    jzjpcc_mmio_ports #(.NUM_PORTS(64), .SYNC_STAGES(2)) u64 (
        .clock(clock), .reset(reset), .memAddress(memAddress),
        .memWriteEnable(memWriteEnable), .memByteMask(memByteMask),
        .memDataToWrite(memDataToWrite), .mmioSelected(sel64),
        .memDataRead(rd64), .mmioInputs(in64), .mmioOutputs(out64),
        .mmioDirection(dir64), .edgePending(ep64)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        expSel;
        logic [31:0] expRead;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic setBus(input logic [31:0] byteAddr, input logic we,
                          input logic [3:0] mask, input logic [31:0] data);
        memAddress     = byteAddr[31:2];
        memWriteEnable = we;
        memByteMask    = mask;
        memDataToWrite = data;
    endtask

    task automatic idle();
        setBus(32'h0000_0000, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'hFFFFFFC0, 1'b0, 4'h0, 32'h0,        1'b1, 32'hFFFFFFFF};
        vecs[1]  = '{32'hFFFFFFA0, 1'b0, 4'h0, 32'h0,        1'b1, 32'h00000000};
        vecs[2]  = '{32'hFFFFFFB4, 1'b0, 4'h0, 32'h0,        1'b1, 32'h00000000};
        vecs[3]  = '{32'hFFFFFFEC, 1'b1, 4'hF, 32'h12345678, 1'b1, 32'h00000000};
        vecs[4]  = '{32'hFFFFFFEC, 1'b1, 4'h5, 32'h9ABCDEF0, 1'b1, 32'h12345678};
        vecs[5]  = '{32'hFFFFFFEC, 1'b0, 4'h0, 32'h0,        1'b1, 32'h12BC56F0};
        vecs[6]  = '{32'hFFFFFFCC, 1'b1, 4'hF, 32'h00000000, 1'b1, 32'hFFFFFFFF};
        vecs[7]  = '{32'hFFFFFFCC, 1'b0, 4'h0, 32'h0,        1'b1, 32'hFFFFFFFF};
        vecs[8]  = '{32'hFFFFFF80, 1'b1, 4'hF, 32'hAAAA5555, 1'b1, 32'h00000000};
        vecs[9]  = '{32'hFFFFFF80, 1'b0, 4'h0, 32'h0,        1'b1, 32'hAAAA5555};
        vecs[10] = '{32'hFFFFFEFC, 1'b0, 4'h0, 32'h0,        1'b0, 32'h00000000};
        vecs[11] = '{32'hFFFFFEFC, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h00000000};
        vecs[12] = '{32'hFFFFFFFC, 1'b0, 4'h0, 32'h0,        1'b1, 32'h00000000};
        vecs[13] = '{32'hFFFFFF9C, 1'b1, 4'hA, 32'h11223344, 1'b1, 32'h00000000};
        vecs[14] = '{32'hFFFFFF9C, 1'b0, 4'h0, 32'h0,        1'b1, 32'h11003300};

        for (int i = 0; i < 8; i++) in8[i] = 32'hFFFFFFFF;
        in8[5] = 32'h0;
        in1    = '0;
        in64   = '0;
        idle();

        // Reset held three cycles with inputs high.
        reset = 1'b1;
        repeat (3) step();
        check("rst_out3", out8[3], 32'h0);
        check("rst_dir0", dir8[0], 32'h0);
        check("rst_read", rd8, 32'h0);
        check("rst_edge", {31'b0, ep8}, 32'h0);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("arming_edge_c%0d", c), {31'b0, ep8}, 32'h0);
        end
        check("post_arm_read", rd8, 32'h0);

        for (int i = 0; i < 15; i++) begin
            setBus(vecs[i].addr, vecs[i].we, vecs[i].mask, vecs[i].data);
            #1;
            check($sformatf("vec%0d_sel", i), {31'b0, sel8},
                  {31'b0, vecs[i].expSel});
            step();
            check($sformatf("vec%0d_read", i), rd8, vecs[i].expRead);
        end
        idle();
        check("out3_masked", out8[3], 32'h12BC56F0);
        check("out_untouched", out8[7], 32'h0);
        check("dir0_value", dir8[0], 32'hAAAA5555);
        check("dir7_masked", dir8[7], 32'h11003300);
        check("no_edge_yet", {31'b0, ep8}, 32'h0);

        // Rising edge on port 5 bit 0 and a plain W1C.
        in8[5] = 32'h1;
        step();
        step();
        check("edge_early", {31'b0, ep8}, 32'h0);
        step();
        check("edge_set", {31'b0, ep8}, 32'h1);
        setBus(32'hFFFFFFB4, 1'b0, 4'h0, 32'h0);
        step();
        check("edge5_read", rd8, 32'h00000001);
        setBus(32'hFFFFFFB4, 1'b1, 4'h1, 32'h00000001);
        step();
        check("w1c_clear", {31'b0, ep8}, 32'h0);
        setBus(32'hFFFFFFB4, 1'b0, 4'h0, 32'h0);
        step();
        check("edge5_cleared", rd8, 32'h0);
        idle();

        // W1C landing in the same cycle the edge registers.
        in8[5] = 32'h0;
        repeat (4) step();
        in8[5] = 32'h1;
        step();
        step();
        setBus(32'hFFFFFFB4, 1'b1, 4'h1, 32'h00000001);
        step();
        check("set_wins", {31'b0, ep8}, 32'h1);
        setBus(32'hFFFFFFB4, 1'b0, 4'h0, 32'h0);
        step();
        check("set_wins_read", rd8, 32'h00000001);
        setBus(32'hFFFFFFB4, 1'b1, 4'h1, 32'h00000001);
        step();
        check("w1c_after", {31'b0, ep8}, 32'h0);
        idle();

        // Single port, bypassed synchroniser.
        setBus(32'hFFFFFFF0, 1'b0, 4'h0, 32'h0);
        #1;
        check("np1_base_sel", {31'b0, sel1}, 32'h1);
        setBus(32'hFFFFFFEC, 1'b0, 4'h0, 32'h0);
        #1;
        check("np1_below_sel", {31'b0, sel1}, 32'h0);
        setBus(32'hFFFFFFF8, 1'b0, 4'h0, 32'h0);
        in1[0] = 32'h000000A5;
        step();
        check("np1_in_latency", rd1, 32'h000000A5);
        check("np1_edge", {31'b0, ep1}, 32'h1);

        // 64-port region boundary.
        setBus(32'hFFFFFC00, 1'b0, 4'h0, 32'h0);
        #1;
        check("np64_base_sel", {31'b0, sel64}, 32'h1);
        setBus(32'hFFFFFBFC, 1'b0, 4'h0, 32'h0);
        #1;
        check("np64_below_sel", {31'b0, sel64}, 32'h0);
        idle();
        step();

        // Reset colliding with a write; arming must restart.
        setBus(32'hFFFFFFE4, 1'b1, 4'hF, 32'hFFFFFFFF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        check("midrst_out1", out8[1], 32'h0);
        check("midrst_out3", out8[3], 32'h0);
        check("midrst_dir0", dir8[0], 32'h0);
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("rearm_edge_c%0d", c), {31'b0, ep8}, 32'h0);
        end
        setBus(32'hFFFFFFC0, 1'b0, 4'h0, 32'h0);
        step();
        check("rearm_in0", rd8, 32'hFFFFFFFF);
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
